// File: rtl/dqs_dly_scan_if.sv
// dqs_dly_scan_if: scan request, delay-line drive and per-tap result bundle for the DQS tap scanner
interface dqs_dly_scan_if #(
    parameter int DLY_WIDTH = 5
);
    logic                 start;
    logic                 dly_ready;
    logic                 sample_in;
    logic [DLY_WIDTH-1:0] dly_data;
    logic                 ld;
    logic                 set;
    logic                 busy;
    logic                 done;
    logic                 res_valid;
    logic [DLY_WIDTH-1:0] res_tap;
    logic [7:0]           res_ones;
    logic                 edge_found;
    logic [DLY_WIDTH-1:0] edge_tap;
    modport master (
        input  start, dly_ready, sample_in,
        output dly_data, ld, set, busy, done, res_valid, res_tap, res_ones, edge_found, edge_tap
    );
    modport slave (
        output start, dly_ready, sample_in,
        input  dly_data, ld, set, busy, done, res_valid, res_tap, res_ones, edge_found, edge_tap
    );
endinterface

// File: rtl/dqs_dly_scan.sv
// dqs_dly_scan: sweeps the DQS delay tap range and reports the first tap where the sampled majority flips
module dqs_dly_scan #(
    parameter int DLY_WIDTH     = 5,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_COUNT  = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    dqs_dly_scan_if.master m_if
);
    typedef enum logic [2:0] {IDLE, WAIT_RDY, LOAD, SET, SETTLE, SAMPLE, REPORT, FIN} state_t;
    localparam logic [DLY_WIDTH-1:0] TAP_MAX = '1;
    state_t               r_state, w_next;
    logic [DLY_WIDTH-1:0] r_tap, r_dly, r_edge_tap, w_dly;
    logic [15:0]          r_cnt;
    logic [7:0]           r_ones;
    logic [1:0]           r_sync;
    logic                 r_prev_maj, r_edge_found, w_maj, w_abort, w_accept, w_commit;
    // losing IDELAYCTRL ready anywhere in the per-tap sequence throws that attempt away
    assign w_abort  = (r_state inside {LOAD, SET, SETTLE, SAMPLE, REPORT}) && !m_if.dly_ready;
    assign w_accept = (r_state == IDLE) && m_if.start;
    assign w_commit = (r_state == REPORT) && m_if.dly_ready;
    assign w_maj    = {r_ones, 1'b0} > 9'(SAMPLE_COUNT);
    assign w_dly    = (r_state == LOAD || r_state == SET) ? r_tap : r_dly;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = m_if.start ? WAIT_RDY : IDLE;
            WAIT_RDY: w_next = m_if.dly_ready ? LOAD : WAIT_RDY;
            LOAD:     w_next = SET;
            SET:      w_next = SETTLE;
            SETTLE:   w_next = (r_cnt == 16'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
            SAMPLE:   w_next = (r_cnt == 16'(SAMPLE_COUNT - 1)) ? REPORT : SAMPLE;
            REPORT:   w_next = (r_tap == TAP_MAX) ? FIN : LOAD;
            FIN:      w_next = IDLE;
            default:  w_next = IDLE;
        endcase
        if (w_abort) w_next = WAIT_RDY;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_tap        <= '0;
            r_dly        <= '0;
            r_cnt        <= '0;
            r_ones       <= '0;
            r_sync       <= '0;
            r_prev_maj   <= 1'b0;
            r_edge_found <= 1'b0;
            r_edge_tap   <= '0;
        end else begin
            r_state <= w_next;
            r_sync  <= {r_sync[0], m_if.sample_in};
            r_dly   <= w_dly;
            r_cnt   <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
            r_ones  <= (r_state == SAMPLE && !w_abort) ? r_ones + 8'(r_sync[1]) : 8'd0;
            if (w_accept) begin
                r_tap        <= '0;
                r_edge_found <= 1'b0;
                r_edge_tap   <= '0;
            end
            if (w_commit) begin
                r_prev_maj <= w_maj;
                if (r_tap != TAP_MAX) r_tap <= r_tap + DLY_WIDTH'(1);
                if (r_tap != '0 && !r_edge_found && w_maj != r_prev_maj) begin
                    r_edge_found <= 1'b1;
                    r_edge_tap   <= r_tap;
                end
            end
        end
    end
    assign m_if.dly_data   = w_dly;
    assign m_if.ld         = r_state == LOAD;
    assign m_if.set        = r_state == SET;
    assign m_if.busy       = r_state != IDLE;
    assign m_if.done       = r_state == FIN;
    assign m_if.res_valid  = w_commit;
    assign m_if.res_tap    = r_tap;
    assign m_if.res_ones   = r_ones;
    assign m_if.edge_found = r_edge_found;
    assign m_if.edge_tap   = r_edge_tap;
endmodule

// File: tb/tb_dqs_dly_scan.sv
// tb_dqs_dly_scan: directed scans with a loopback model keyed on the last applied tap
module tb_dqs_dly_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   mode = 0;
    int   done_cnt = 0;
    int   res_cnt = 0;
    int   acnt = 0;
    bit   abort_en = 1'b0;
    bit   aborted = 1'b0;
    bit   ph = 1'b0;
    logic [4:0] applied = '0;
    int   res_arr [32];
    int   ld_cnt [32];
    dqs_dly_scan_if #(.DLY_WIDTH(5)) bus ();
    dqs_dly_scan dut (.i_clk(clk), .i_rst(rst), .m_if(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask
    // loopback level: 0 const, 1 step at 12, 2 low for taps 5..19, 3 alternating, 4 const high
    function automatic bit pat(int m, logic [4:0] t, bit p);
        return m == 1 ? (t >= 5'd12) : m == 2 ? (t < 5'd5 || t >= 5'd20) : m == 3 ? p : (m == 4);
    endfunction
    function automatic int exp_ones(int m, int t);
        return m == 3 ? 8 : (pat(m, 5'(t), 1'b0) ? 16 : 0);
    endfunction
    initial begin
        bus.dly_ready = 1'b1;
        bus.sample_in = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.res_valid) begin
                res_cnt++;
                res_arr[bus.res_tap] = int'(bus.res_ones);
            end
            if (bus.done) done_cnt++;
            if (bus.ld) ld_cnt[bus.dly_data]++;
            if (bus.set) applied = bus.dly_data;
            if (abort_en && !aborted && bus.set && bus.dly_data == 5'd7) acnt = 1;
            else if (acnt > 0) acnt++;
            if (acnt == 24) begin
                aborted = 1'b1;
                acnt = 0;
            end
            bus.dly_ready = !(acnt >= 14);
            ph = ~ph;
            bus.sample_in = pat(mode, applied, ph);
        end
    end
    task automatic scan(input int m, input int exp_cyc, input int exp_found, input int exp_tap);
        int cyc = 0;
        mode = m;
        done_cnt = 0;
        res_cnt = 0;
        foreach (ld_cnt[i]) ld_cnt[i] = 0;
        foreach (res_arr[i]) res_arr[i] = -1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        while (!bus.done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("m%0d_done_seen", m), int'(bus.done), 1);
        if (exp_cyc > 0) check($sformatf("m%0d_start_to_done", m), cyc, exp_cyc);
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("m%0d_done_pulses", m), done_cnt, 1);
        check($sformatf("m%0d_res_count", m), res_cnt, 32);
        check($sformatf("m%0d_busy_after", m), int'(bus.busy), 0);
        check($sformatf("m%0d_edge_found", m), int'(bus.edge_found), exp_found);
        check($sformatf("m%0d_edge_tap", m), int'(bus.edge_tap), exp_tap);
        for (int t = 0; t < 32; t++) begin
            check($sformatf("m%0d_ones_t%0d", m, t), res_arr[t], exp_ones(m, t));
            check($sformatf("m%0d_loads_t%0d", m, t), ld_cnt[t], (abort_en && t == 7) ? 2 : 1);
        end
    endtask
    initial begin
        int cyc;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", int'({bus.busy, bus.done, bus.ld, bus.set, bus.res_valid, bus.edge_found}), 0);
        check("rst_buses", int'({bus.dly_data, bus.res_tap, bus.res_ones, bus.edge_tap}), 0);
        rst = 1'b0;
        scan(0, 865, 0, 0);
        scan(1, 865, 1, 12);
        scan(2, 865, 1, 5);
        scan(3, 865, 0, 0);
        abort_en = 1'b1;
        scan(4, 0, 0, 0);
        abort_en = 1'b0;
        mode = 1;
        done_cnt = 0;
        foreach (ld_cnt[i]) ld_cnt[i] = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!(bus.ld && bus.dly_data == 5'd3) && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("busy_start_ignored", ld_cnt[0], 1);
        check("tap3_reached", int'(bus.ld && bus.dly_data == 5'd3), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_flags", int'({bus.busy, bus.done, bus.ld, bus.set, bus.res_valid, bus.edge_found}), 0);
        check("midrst_buses", int'({bus.dly_data, bus.res_tap, bus.res_ones, bus.edge_tap}), 0);
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, 0);
        check("midrst_idle", int'(bus.busy), 0);
        scan(2, 865, 1, 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
